// File: rtl/rgb2yuv422_enc.sv
// rgb2yuv422_enc
//   Converts pairs of 24-bit RGB pixels to fixed-point YUV. Each pair goes out
//   as the 4:2:2 byte burst U, Y0, V, Y1. Y is unsigned; U and V are
//   two's-complement.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   in_en      in   rgb_in valid this cycle (ignored while busy)
//   rgb_in     in   {R[23:16], G[15:8], B[7:0]}, unsigned
//   busy       out  high while the group is converted and emitted
//   out_valid  out  yuv_out carries a valid byte
//   yuv_out    out  byte stream U, Y0, V, Y1; 0x00 when not emitting
//
// Build option
//   CTE_ENC_CHROMA_AVG_EN: when defined, U/V are computed from the pair sums
//   and rounded with one extra fractional bit. When undefined, U/V come from
//   pixel 0 only.

module rgb2yuv422_enc #(
    parameter int unsigned COEF_FRAC = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_en,
    input  logic [23:0] rgb_in,
    output logic        busy,
    output logic        out_valid,
    output logic [7:0]  yuv_out
);

    typedef enum logic [2:0] {
        StP0,
        StP1,
        StCalc,
        StEu,
        StEy0,
        StEv,
        StEy1
    } state_e;

    // Coefficients scaled by 2^COEF_FRAC
    localparam logic signed [8:0] CyR = 9'sd77;
    localparam logic signed [8:0] CyG = 9'sd150;
    localparam logic signed [8:0] CyB = 9'sd29;
    localparam logic signed [8:0] CuR = -9'sd43;
    localparam logic signed [8:0] CuG = -9'sd85;
    localparam logic signed [8:0] CuB = 9'sd128;
    localparam logic signed [8:0] CvR = 9'sd128;
    localparam logic signed [8:0] CvG = -9'sd107;
    localparam logic signed [8:0] CvB = -9'sd21;

    localparam int unsigned YShift = COEF_FRAC;
`ifdef CTE_ENC_CHROMA_AVG_EN
    // Pair sums carry an extra factor of two, folded into the rounding shift
    localparam int unsigned CShift = COEF_FRAC + 1;
`else
    localparam int unsigned CShift = COEF_FRAC;
`endif
    localparam logic signed [18:0] YBias = 19'(1 << (YShift - 1));
    localparam logic signed [18:0] CBias = 19'(1 << (CShift - 1));

    state_e      state_q, state_d;
    logic [23:0] pix0_q, pix0_d;
    logic [23:0] pix1_q, pix1_d;
    logic [7:0]  y0_q, y0_d;
    logic [7:0]  y1_q, y1_d;
    logic [7:0]  u_q, u_d;
    logic [7:0]  v_q, v_d;

    // Chroma operands, zero-extended to 10 bits so a pair sum fits
    logic [9:0] cr, cg, cb;

    // Unsigned operand times signed coefficient in the 19-bit accumulator domain
    function automatic logic signed [18:0] mulc(input logic [9:0] x,
                                                input logic signed [8:0] c);
        logic signed [18:0] xs;
        logic signed [18:0] cs;
        xs = $signed({9'b0, x});
        cs = {{10{c[8]}}, c};
        return xs * cs;
    endfunction

    function automatic logic [7:0] luma(input logic [23:0] px);
        logic signed [18:0] acc;
        logic signed [18:0] r;
        acc = mulc({2'b0, px[23:16]}, CyR) + mulc({2'b0, px[15:8]}, CyG)
            + mulc({2'b0, px[7:0]}, CyB);
        r = (acc + YBias) >>> YShift;
        if (r < 19'sd0) begin
            return 8'h00;
        end else if (r > 19'sd255) begin
            return 8'hFF;
        end
        return r[7:0];
    endfunction

    // Arithmetic shift rounds half toward +inf, then saturate to int8
    function automatic logic [7:0] chroma(input logic signed [18:0] acc);
        logic signed [18:0] r;
        r = (acc + CBias) >>> CShift;
        if (r < -19'sd128) begin
            return 8'h80;
        end else if (r > 19'sd127) begin
            return 8'h7F;
        end
        return r[7:0];
    endfunction

`ifdef CTE_ENC_CHROMA_AVG_EN
    assign cr = {2'b0, pix0_q[23:16]} + {2'b0, pix1_q[23:16]};
    assign cg = {2'b0, pix0_q[15:8]}  + {2'b0, pix1_q[15:8]};
    assign cb = {2'b0, pix0_q[7:0]}   + {2'b0, pix1_q[7:0]};
`else
    assign cr = {2'b0, pix0_q[23:16]};
    assign cg = {2'b0, pix0_q[15:8]};
    assign cb = {2'b0, pix0_q[7:0]};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StP0;
            pix0_q  <= '0;
            pix1_q  <= '0;
            y0_q    <= '0;
            y1_q    <= '0;
            u_q     <= '0;
            v_q     <= '0;
        end else begin
            state_q <= state_d;
            pix0_q  <= pix0_d;
            pix1_q  <= pix1_d;
            y0_q    <= y0_d;
            y1_q    <= y1_d;
            u_q     <= u_d;
            v_q     <= v_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pix0_d  = pix0_q;
        pix1_d  = pix1_q;
        y0_d    = y0_q;
        y1_d    = y1_q;
        u_d     = u_q;
        v_d     = v_q;
        unique case (state_q)
            StP0: begin
                if (in_en) begin
                    pix0_d  = rgb_in;
                    state_d = StP1;
                end
            end
            StP1: begin
                if (in_en) begin
                    pix1_d  = rgb_in;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                y0_d    = luma(pix0_q);
                y1_d    = luma(pix1_q);
                u_d     = chroma(mulc(cr, CuR) + mulc(cg, CuG) + mulc(cb, CuB));
                v_d     = chroma(mulc(cr, CvR) + mulc(cg, CvG) + mulc(cb, CvB));
                state_d = StEu;
            end
            StEu:    state_d = StEy0;
            StEy0:   state_d = StEv;
            StEv:    state_d = StEy1;
            StEy1:   state_d = StP0;
            default: state_d = StP0;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        out_valid = 1'b0;
        yuv_out   = 8'h00;
        unique case (state_q)
            StP0, StP1: begin
                busy = 1'b0;
            end
            StCalc: begin
                busy = 1'b1;
            end
            StEu: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                yuv_out   = u_q;
            end
            StEy0: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                yuv_out   = y0_q;
            end
            StEv: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                yuv_out   = v_q;
            end
            StEy1: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                yuv_out   = y1_q;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_rgb2yuv422_enc.sv
// Self-checking bench for rgb2yuv422_enc: directed and random pixel pairs
// compared against an arithmetic reference model of the conversion.

module tb_rgb2yuv422_enc;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_en;
    logic [23:0] rgb_in;
    logic        busy;
    logic        out_valid;
    logic [7:0]  yuv_out;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    rgb2yuv422_enc #(
        .COEF_FRAC(8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_en    (in_en),
        .rgb_in   (rgb_in),
        .busy     (busy),
        .out_valid(out_valid),
        .yuv_out  (yuv_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int fdiv(input int n, input int d);
        if (n >= 0) return n / d;
        return -((-n + d - 1) / d);
    endfunction

    function automatic int clampi(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic logic [7:0] model_y(input logic [23:0] p);
        int r, g, b;
        r = int'(p[23:16]);
        g = int'(p[15:8]);
        b = int'(p[7:0]);
        return 8'(clampi(fdiv(77 * r + 150 * g + 29 * b + 128, 256), 0, 255));
    endfunction

    function automatic logic [7:0] model_c(input logic [23:0] p0, input logic [23:0] p1,
                                           input bit is_v);
        int r, g, b, acc, den;
`ifdef CTE_ENC_CHROMA_AVG_EN
        r   = int'(p0[23:16]) + int'(p1[23:16]);
        g   = int'(p0[15:8]) + int'(p1[15:8]);
        b   = int'(p0[7:0]) + int'(p1[7:0]);
        den = 512;
`else
        r   = int'(p0[23:16]);
        g   = int'(p0[15:8]);
        b   = int'(p0[7:0]);
        den = 256;
`endif
        if (is_v) acc = 128 * r - 107 * g - 21 * b;
        else      acc = -43 * r - 85 * g + 128 * b;
        return 8'(clampi(fdiv(acc + den / 2, den), -128, 127));
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends one pair and checks the burst cycle by cycle. With hold set, in_en
    // stays high with junk data during the busy window, which must be ignored.
    task automatic send_pair(input string tag, input logic [23:0] p0, input logic [23:0] p1,
                             input int gap, input bit hold);
        logic [7:0] exp_b [4];
        exp_b[0] = model_c(p0, p1, 1'b0);
        exp_b[1] = model_y(p0);
        exp_b[2] = model_c(p0, p1, 1'b1);
        exp_b[3] = model_y(p1);

        in_en  = 1'b1;
        rgb_in = p0;
        tick();
        check({tag, "_p0_busy"}, 32'(busy), 32'd0);
        for (int i = 0; i < gap; i++) begin
            in_en  = 1'b0;
            rgb_in = 24'($urandom);
            tick();
            check({tag, "_gap_valid"}, 32'(out_valid), 32'd0);
        end
        in_en  = 1'b1;
        rgb_in = p1;
        tick();
        check({tag, "_calc_busy"}, 32'(busy), 32'd1);
        check({tag, "_calc_valid"}, 32'(out_valid), 32'd0);
        for (int k = 0; k < 4; k++) begin
            in_en  = hold;
            rgb_in = 24'($urandom);
            tick();
            check($sformatf("%s_valid%0d", tag, k), 32'(out_valid), 32'd1);
            check($sformatf("%s_byte%0d", tag, k), 32'(yuv_out), 32'(exp_b[k]));
        end
        in_en  = hold;
        rgb_in = 24'($urandom);
        tick();
        check({tag, "_end_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_end_busy"}, 32'(busy), 32'd0);
        in_en = 1'b0;
    endtask

    function automatic logic [7:0] rand_comp();
        int unsigned sel;
        sel = $urandom_range(0, 3);
        if (sel == 0) return 8'h00;
        if (sel == 1) return 8'hFF;
        return 8'($urandom);
    endfunction

    initial begin
        logic [23:0] ra, rb;
        reset  = 1'b1;
        in_en  = 1'b0;
        rgb_in = '0;
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        reset = 1'b0;
        tick();
        tick();
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_valid", 32'(out_valid), 32'd0);
        check("idle_yuv", 32'(yuv_out), 32'd0);

        send_pair("white", 24'hFFFFFF, 24'hFFFFFF, 0, 1'b0);
        send_pair("red", 24'hFF0000, 24'hFF0000, 0, 1'b0);
        send_pair("blue", 24'h0000FF, 24'h000000, 2, 1'b0);
        send_pair("red_blk", 24'hFF0000, 24'h000000, 1, 1'b0);
        send_pair("grn_hold", 24'h00FF00, 24'h123456, 0, 1'b1);
        send_pair("chain", 24'h80FF10, 24'hFF0080, 0, 1'b1);

        // Reset during the V byte drops the rest of the burst
        in_en  = 1'b1;
        rgb_in = 24'hFF0000;
        tick();
        rgb_in = 24'h00FF00;
        tick();
        in_en = 1'b0;
        tick();
        tick();
        tick();
        check("pre_rst_ev_valid", 32'(out_valid), 32'd1);
        reset = 1'b1;
        tick();
        check("rst_ev_valid", 32'(out_valid), 32'd0);
        check("rst_ev_busy", 32'(busy), 32'd0);
        check("rst_ev_yuv", 32'(yuv_out), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("post_rst_valid", 32'(out_valid), 32'd0);
        end

        // Reset after a lone P0 discards it
        in_en  = 1'b1;
        rgb_in = 24'hABCDEF;
        tick();
        in_en = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        send_pair("after_part", 24'h204060, 24'hC0A080, 0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            ra = {rand_comp(), rand_comp(), rand_comp()};
            rb = {rand_comp(), rand_comp(), rand_comp()};
            send_pair($sformatf("rnd%0d", n), ra, rb, int'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
